// File: rtl/id_stage_hz.sv
// Decode stage: register file, load-use hazard detection with bubble insertion, ID/EX register.
// Optional macro ID_WB_BYPASS_EN makes register reads write-through from the WB port.
module id_stage_hz #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  input  logic [AW-1:0]     rs1_i,
  input  logic [AW-1:0]     rs2_i,
  input  logic [AW-1:0]     rd_i,
  input  logic              uses_rs1_i,
  input  logic              uses_rs2_i,
  input  logic              is_load_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   pcPlus4_i,
  input  logic              RegWriteWB_i,
  input  logic [AW-1:0]     writeRegAddr_i,
  input  logic [XLEN-1:0]   WD3_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              is_load_o,
  output logic [XLEN-1:0]   rs1Data_o,
  output logic [XLEN-1:0]   rs2Data_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   pcPlus4_o,
  output logic [AW-1:0]     rd_o,
  output logic [AW-1:0]     rs1_o,
  output logic [AW-1:0]     rs2_o,
  output logic [2:0]        funct3_o,
  output logic [XLEN-1:0]   a0_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam logic [AW-1:0] A0_IDX = AW'(10);

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   rs1_rd, rs2_rd;
  logic              hz;

  logic              valid_q, valid_d, is_load_q, is_load_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d, pc_q, pc_d, pc4_q, pc4_d;
  logic [AW-1:0]     rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]        f3_q, f3_d;
  logic [CNT_W-1:0]  bub_q, bub_d;

  // Register file storage: synchronous clear, single WB write port, x0 never written
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (RegWriteWB_i && (writeRegAddr_i != '0)) begin
      regs_q[writeRegAddr_i] <= WD3_i;
    end
  end

  // Combinational operand read, x0 forced to zero
  always_comb begin
    rs1_rd = (rs1_i == '0) ? '0 : regs_q[rs1_i];
    rs2_rd = (rs2_i == '0) ? '0 : regs_q[rs2_i];
`ifdef ID_WB_BYPASS_EN
    // Write-through covers the WB-to-ID distance; a nonzero match implies a nonzero source
    if (RegWriteWB_i && (writeRegAddr_i != '0) && (writeRegAddr_i == rs1_i)) rs1_rd = WD3_i;
    if (RegWriteWB_i && (writeRegAddr_i != '0) && (writeRegAddr_i == rs2_i)) rs2_rd = WD3_i;
`endif
  end

  assign hz = valid_i & valid_q & is_load_q & (rd_q != '0) &
              ((uses_rs1_i & (rs1_i == rd_q)) | (uses_rs2_i & (rs2_i == rd_q)));
  assign stall_o = hold_i | (hz & ~flush_i);

  // ID/EX next state: flush > hold > bubble > load
  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    is_load_d  = is_load_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    f3_d       = f3_q;
    bub_d      = bub_q;
    if (flush_i) begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      is_load_d = 1'b0;
      rd_d      = '0;
    end else if (!hold_i) begin
      if (hz) begin
        valid_d   = 1'b0;
        ctrl_d    = '0;
        is_load_d = 1'b0;
        rd_d      = '0;
        if (bub_q != '1) begin
          bub_d = bub_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          bub_d = bub_q;
        end
      end else begin
        valid_d    = valid_i;
        ctrl_d     = valid_i ? ctrl_i : '0;
        is_load_d  = valid_i & is_load_i;
        rs1_data_d = rs1_rd;
        rs2_data_d = rs2_rd;
        imm_d      = imm_i;
        pc_d       = pc_i;
        pc4_d      = pcPlus4_i;
        rd_d       = rd_i;
        rs1_d      = rs1_i;
        rs2_d      = rs2_i;
        f3_d       = funct3_i;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // ID/EX register and bubble counter
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      is_load_q  <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      pc4_q      <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      f3_q       <= 3'b000;
      bub_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      is_load_q  <= is_load_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      f3_q       <= f3_d;
      bub_q      <= bub_d;
    end
  end

  assign valid_o      = valid_q;
  assign ctrl_o       = ctrl_q;
  assign is_load_o    = is_load_q;
  assign rs1Data_o    = rs1_data_q;
  assign rs2Data_o    = rs2_data_q;
  assign imm_o        = imm_q;
  assign pc_o         = pc_q;
  assign pcPlus4_o    = pc4_q;
  assign rd_o         = rd_q;
  assign rs1_o        = rs1_q;
  assign rs2_o        = rs2_q;
  assign funct3_o     = f3_q;
  assign a0_o         = regs_q[A0_IDX];
  assign bubble_cnt_o = bub_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Scoreboard bench for id_stage_hz: a behavioural model predicts each ID/EX state, a monitor compares.
module tb_id_stage_hz;
  localparam int XLEN = 32, NREGS = 32, CTRL_W = 12, CNT_W = 4, AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, valid, u1, u2, ld, we, hold, flush;
  logic [AW-1:0] rs1, rs2, rd, wa;
  logic [CTRL_W-1:0] ctrl;
  logic [XLEN-1:0] imm, pc, pc4, wd;
  logic [2:0] f3;
  logic stall_o, valid_o, is_load_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [XLEN-1:0] rs1d_o, rs2d_o, imm_o, pc_o, pc4_o, a0_o;
  logic [AW-1:0] rd_o, rs1_o, rs2_o;
  logic [2:0] f3_o;
  logic [CNT_W-1:0] bub_o;

  id_stage_hz #(.XLEN(XLEN), .NREGS(NREGS), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
    .uses_rs1_i(u1), .uses_rs2_i(u2), .is_load_i(ld), .ctrl_i(ctrl), .imm_i(imm),
    .funct3_i(f3), .pc_i(pc), .pcPlus4_i(pc4), .RegWriteWB_i(we), .writeRegAddr_i(wa),
    .WD3_i(wd), .hold_i(hold), .flush_i(flush), .stall_o(stall_o), .valid_o(valid_o),
    .ctrl_o(ctrl_o), .is_load_o(is_load_o), .rs1Data_o(rs1d_o), .rs2Data_o(rs2d_o),
    .imm_o(imm_o), .pc_o(pc_o), .pcPlus4_o(pc4_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .funct3_o(f3_o), .a0_o(a0_o), .bubble_cnt_o(bub_o));

  typedef struct {
    logic v; logic [CTRL_W-1:0] ctrl; logic ld;
    logic [XLEN-1:0] d1, d2, imm, pc, pc4, a0;
    logic [AW-1:0] rd, rs1, rs2; logic [2:0] f3; int bub;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;
  logic [XLEN-1:0] m_regs [NREGS];
  int checks = 0, failures = 0;

  task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] model_read(logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef ID_WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_regs[a];
  endfunction

  // One cycle: inputs are already set at the falling edge
  task automatic step();
    exp_t n;
    bit hz;
    #1;
    hz = valid && m.v && m.ld && (m.rd != 0) &&
         ((u1 && rs1 == m.rd) || (u2 && rs2 == m.rd));
    chk("stall", {31'd0, stall_o}, {31'd0, (hold || (hz && !flush))});
    n = m;
    if (!rst_n) begin
      n = '{v:0, ctrl:0, ld:0, d1:0, d2:0, imm:0, pc:0, pc4:0, a0:0, rd:0, rs1:0, rs2:0, f3:0, bub:0};
    end else if (flush || (!hold && hz)) begin
      n.v = 0; n.ctrl = 0; n.ld = 0; n.rd = 0;
      if (!flush) n.bub = (m.bub == (1 << CNT_W) - 1) ? m.bub : m.bub + 1;
    end else if (!hold) begin
      n.v = valid; n.ctrl = valid ? ctrl : '0; n.ld = valid && ld;
      n.d1 = model_read(rs1); n.d2 = model_read(rs2);
      n.imm = imm; n.pc = pc; n.pc4 = pc4; n.rd = rd; n.rs1 = rs1; n.rs2 = rs2; n.f3 = f3;
    end
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    end else if (we && wa != 0) begin
      m_regs[wa] = wd;
    end
    n.a0 = m_regs[10];
    sb_q.push_back(n);
    m = n;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every cycle after the edge, compare DUT state with the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("valid", {31'd0, valid_o}, {31'd0, e.v});
        chk("ctrl", {20'd0, ctrl_o}, {20'd0, e.ctrl});
        chk("is_load", {31'd0, is_load_o}, {31'd0, e.ld});
        chk("rs1Data", rs1d_o, e.d1);
        chk("rs2Data", rs2d_o, e.d2);
        chk("imm", imm_o, e.imm);
        chk("pc", pc_o, e.pc);
        chk("pcPlus4", pc4_o, e.pc4);
        chk("rd", {27'd0, rd_o}, {27'd0, e.rd});
        chk("rs1", {27'd0, rs1_o}, {27'd0, e.rs1});
        chk("rs2", {27'd0, rs2_o}, {27'd0, e.rs2});
        chk("funct3", {29'd0, f3_o}, {29'd0, e.f3});
        chk("a0", a0_o, e.a0);
        chk("bubble_cnt", {28'd0, bub_o}, e.bub[XLEN-1:0]);
      end
    end
  end

  task automatic idle();
    valid = 0; u1 = 0; u2 = 0; ld = 0; we = 0; hold = 0; flush = 0;
    rs1 = 0; rs2 = 0; rd = 0; wa = 0; ctrl = 0; imm = 0; pc = 0; pc4 = 0; wd = 0; f3 = 0;
  endtask

  task automatic instr(logic [AW-1:0] a1, logic [AW-1:0] a2, logic [AW-1:0] d,
                       logic uu1, logic uu2, logic isld);
    valid = 1; rs1 = a1; rs2 = a2; rd = d; u1 = uu1; u2 = uu2; ld = isld;
    ctrl = 12'($urandom); imm = $urandom; pc = $urandom; pc4 = pc + 32'd4; f3 = 3'($urandom);
  endtask

  initial begin
    m = '{v:0, ctrl:0, ld:0, d1:0, d2:0, imm:0, pc:0, pc4:0, a0:0, rd:0, rs1:0, rs2:0, f3:0, bub:0};
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    idle(); rst_n = 0;
    @(negedge clk);
    step(); step();
    rst_n = 1;
    // read every register after reset
    for (int i = 0; i < NREGS; i += 2) begin instr(5'(i), 5'(i + 1), 5'd0, 1, 1, 0); step(); end
    // write x5, then read it; write x0, then read it; write a0
    idle(); we = 1; wa = 5'd5; wd = 32'hDEADBEEF; step();
    instr(5'd5, 5'd0, 5'd1, 1, 0, 0); wa = 5'd0; wd = 32'h1234; we = 1; step();
    we = 1; wa = 5'd10; wd = 32'hA0A0_0001; instr(5'd0, 5'd5, 5'd2, 1, 1, 0); step();
    // load-use hazard on rs2, then rd=0 and uses_rs2=0 variants
    we = 0; instr(5'd1, 5'd2, 5'd7, 1, 0, 1); step();
    instr(5'd1, 5'd7, 5'd8, 1, 1, 0); step(); step(); step();
    instr(5'd1, 5'd2, 5'd0, 1, 0, 1); step();
    instr(5'd0, 5'd0, 5'd8, 1, 1, 0); step();
    instr(5'd1, 5'd2, 5'd7, 1, 0, 1); step();
    instr(5'd1, 5'd7, 5'd8, 1, 0, 0); step();
    // flush and hold together
    instr(5'd3, 5'd4, 5'd9, 1, 1, 0); flush = 1; hold = 1; step();
    flush = 0; hold = 0; step();
    // hold for three cycles with changing inputs, then release
    for (int i = 0; i < 3; i++) begin instr(5'(i), 5'(i + 2), 5'(i + 3), 1, 1, 0); hold = 1; step(); end
    hold = 0; instr(5'd5, 5'd10, 5'd11, 1, 1, 0); step();
    // same-cycle WB write and read of x3
    idle(); we = 1; wa = 5'd3; wd = 32'h11; step();
    instr(5'd3, 5'd3, 5'd12, 1, 1, 0); we = 1; wa = 5'd3; wd = 32'h55; step();
    we = 0; step();
    // back-to-back load x1 <- x1 forces repeated bubbles past counter saturation
    instr(5'd1, 5'd0, 5'd1, 1, 0, 1);
    for (int i = 0; i < 2 * (1 << CNT_W) + 6; i++) step();
    // reset asserted mid-stall
    instr(5'd1, 5'd0, 5'd1, 1, 0, 1); step();
    rst_n = 0; step();
    rst_n = 1; step();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 1'($urandom));
      valid = ($urandom_range(0, 3) != 0);
      we = 1'($urandom); wa = 5'($urandom_range(0, 11)); wd = $urandom;
      hold = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1; idle();
    @(posedge clk); #2;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
